// File: rtl/sdpram_2048x9.sv
// sdpram_2048x9: simple dual-port RAM, one write port and one read port on one clock.
// Ports: clk, rst_n (async low), wr_en/wr_addr/wr_data, rd_addr, rd_clk_en, rd_data.
module sdpram_2048x9 #(
  parameter int ADDR_WIDTH = 11,
  parameter int DATA_WIDTH = 9,
  parameter bit OUTPUT_REG = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic                  rd_clk_en,
  output logic [DATA_WIDTH-1:0] rd_data
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] rd_q;

  // Contents survive reset; only the write strobe is gated by it.
  always_ff @(posedge clk) begin
    if (rst_n && wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Non-blocking update of mem gives read-first on an address collision.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_q <= '0;
    end else if (rd_clk_en) begin
      rd_q <= mem[rd_addr];
    end
  end

  if (OUTPUT_REG) begin : g_oreg
    logic [DATA_WIDTH-1:0] rd_o;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rd_o <= '0;
      end else if (rd_clk_en) begin
        rd_o <= rd_q;
      end
    end

    assign rd_data = rd_o;
  end else begin : g_noreg
    assign rd_data = rd_q;
  end

endmodule

// File: tb/tb_sdpram_2048x9.sv
// tb_sdpram_2048x9: random and directed checks of both latency variants
// against an array-based reference model.
module tb_sdpram_2048x9;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wr_en = 1'b0;
  logic [10:0] wr_addr = '0;
  logic [8:0]  wr_data = '0;
  logic [10:0] rd_addr = '0;
  logic        rd_clk_en = 1'b1;
  logic [8:0]  rd_l1;
  logic [8:0]  rd_l2;

  int checks = 0;
  int failures = 0;

  logic [8:0] mm [2048];
  bit         mv [2048];
  logic [8:0] e1, e2;
  bit         e1v, e2v;

  always #5 clk = ~clk;

  sdpram_2048x9 #(.OUTPUT_REG(1'b0)) u_l1 (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .rd_addr(rd_addr), .rd_clk_en(rd_clk_en),
    .rd_data(rd_l1)
  );

  sdpram_2048x9 #(.OUTPUT_REG(1'b1)) u_l2 (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .rd_addr(rd_addr), .rd_clk_en(rd_clk_en),
    .rd_data(rd_l2)
  );

  task automatic chk(input string tag, input logic [8:0] got,
                     input logic [8:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // One clock: model advances on the rising edge, outputs checked
  // on the falling edge; inputs are changed by callers after return.
  task automatic cyc();
    @(posedge clk);
    if (!rst_n) begin
      e1 = '0; e1v = 1'b1;
      e2 = '0; e2v = 1'b1;
    end else begin
      if (rd_clk_en) begin
        e2 = e1; e2v = e1v;
        e1 = mm[rd_addr]; e1v = mv[rd_addr];
      end
      if (wr_en) begin
        mm[wr_addr] = wr_data;
        mv[wr_addr] = 1'b1;
      end
    end
    @(negedge clk);
    if (e1v) chk("rd_l1", rd_l1, e1);
    if (e2v) chk("rd_l2", rd_l2, e2);
  endtask

  task automatic wr(input int a, input int d);
    wr_en = 1'b1;
    wr_addr = 11'(a);
    wr_data = 9'(d);
    cyc();
    wr_en = 1'b0;
  endtask

  task automatic rst_pulse();
    rst_n = 1'b0;
    #1;
    chk("rst_async_l1", rd_l1, 9'h000);
    chk("rst_async_l2", rd_l2, 9'h000);
    e1 = '0; e1v = 1'b1;
    e2 = '0; e2v = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 2048; i++) mv[i] = 1'b0;
    e1 = '0; e1v = 1'b1;
    e2 = '0; e2v = 1'b1;

    // Reset held 200 ns with reads enabled and writes attempted.
    wr_en = 1'b1;
    wr_data = 9'h1AA;
    for (int i = 0; i < 20; i++) begin
      rd_addr = 11'(i);
      wr_addr = 11'(i);
      @(posedge clk);
      @(negedge clk);
      chk("rst_hold_l1", rd_l1, 9'h000);
      chk("rst_hold_l2", rd_l2, 9'h000);
    end
    wr_en = 1'b0;
    rst_n = 1'b1;

    // Full sweep.
    rd_clk_en = 1'b0;
    for (int a = 0; a < 2048; a++) wr(a, 'h1FF - (a % 512));
    rd_clk_en = 1'b1;
    for (int a = 0; a < 2048; a++) begin
      rd_addr = 11'(a);
      cyc();
      chk("sweep", rd_l1, 9'(32'h1FF - (a % 512)));
    end
    cyc();

    // Latency.
    wr(5, 'h0AB);
    wr(6, 'h033);
    rd_addr = 11'd5;
    cyc();
    rd_addr = 11'd6;
    chk("lat1", rd_l1, 9'h0AB);
    cyc();
    chk("lat2", rd_l2, 9'h0AB);
    cyc();

    // Clock enable hold.
    wr(3, 'h155);
    wr(4, 'h0AA);
    rd_addr = 11'd3;
    cyc();
    cyc();
    chk("ce_pre", rd_l1, 9'h155);
    rd_clk_en = 1'b0;
    rd_addr = 11'd4;
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("ce_hold_l1", rd_l1, 9'h155);
      chk("ce_hold_l2", rd_l2, 9'h155);
    end
    rd_clk_en = 1'b1;
    cyc();
    chk("ce_resume", rd_l1, 9'h0AA);
    cyc();

    // Read-during-write returns old data.
    wr(7, 'h011);
    rd_addr = 11'd7;
    wr(7, 'h1EE);
    chk("rdw_old", rd_l1, 9'h011);
    cyc();
    chk("rdw_new", rd_l1, 9'h1EE);
    chk("rdw_old_l2", rd_l2, 9'h011);

    // Mid-operation reset.
    for (int a = 0; a < 16; a++) wr(a, 'h100 + a * 7);
    for (int a = 0; a < 16; a++) begin
      rd_addr = 11'(a);
      if (a == 8) begin
        rst_pulse();
        wr_en = 1'b1;
        wr_addr = 11'd2;
        wr_data = 9'h000;
        cyc();
        chk("mid_rst_l1", rd_l1, 9'h000);
        chk("mid_rst_l2", rd_l2, 9'h000);
        wr_en = 1'b0;
        rst_n = 1'b1;
      end
      cyc();
    end
    for (int a = 0; a < 16; a++) begin
      rd_addr = 11'(a);
      cyc();
      chk("mid_rst_keep", rd_l1, 9'(32'h100 + a * 7));
    end

    // Randomized traffic with frequent address collisions.
    for (int i = 0; i < 4000; i++) begin
      bit narrow;
      narrow = ($urandom_range(0, 1) == 1);
      wr_en = ($urandom_range(0, 1) == 1);
      rd_clk_en = ($urandom_range(0, 3) != 0);
      wr_data = 9'($urandom);
      wr_addr = narrow ? 11'($urandom_range(0, 15)) : 11'($urandom);
      rd_addr = narrow ? 11'($urandom_range(0, 15)) : 11'($urandom);
      if ($urandom_range(0, 199) == 0) begin
        rst_pulse();
        cyc();
        rst_n = 1'b1;
      end else begin
        cyc();
      end
    end
    wr_en = 1'b0;
    rd_clk_en = 1'b1;
    cyc();
    cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sdpram_2048x9.md
Name: sdpram_2048x9

Overview:
- Simple dual-port synchronous RAM, 2048 words x 9 bits. One write port and one read port, both on a single clock.
- Used as a line/pixel buffer in the video capture and processing datapath.
- Read data comes out unregistered by default: one-cycle read latency. An optional output pipeline register gives two-cycle latency.

Parameters:
- ADDR_WIDTH, 11, address width of both ports; depth = 2**ADDR_WIDTH.
- DATA_WIDTH, 9, word width of both ports.
- OUTPUT_REG, 0, 0 = rd_data straight from the array read register (latency 1); 1 = extra output register (latency 2).

Ports:
- clk  input  1  single clock for write and read ports; rising edge active.
- rst_n  input  1  asynchronous active-low reset.
- wr_en  input  1  write enable.
- wr_addr  input  ADDR_WIDTH  write address.
- wr_data  input  DATA_WIDTH  write data.
- rd_addr  input  ADDR_WIDTH  read address.
- rd_clk_en  input  1  read-port clock enable; gates address sampling and every read-side register.
- rd_data  output  DATA_WIDTH  read data.

Behaviour:
Storage
- Array of 2**ADDR_WIDTH words.
- Contents are not cleared by reset and are undefined at power-up.

Write
- On rising clk with rst_n=1 and wr_en=1: mem[wr_addr] <= wr_data.
- Writes are ignored while rst_n=0.
- No byte enables.

Read, OUTPUT_REG=0
- On rising clk with rd_clk_en=1: rd_data <= mem[rd_addr].
- Data for an address presented in cycle N is valid after edge N+1.

Read, OUTPUT_REG=1
- Stage 1: rd_q <= mem[rd_addr].
- Stage 2: rd_data <= rd_q.
- Both stages advance only when rd_clk_en=1, giving latency 2 enabled cycles.

Clock enable
- rd_clk_en=0: rd_data and the internal read registers hold their values, and rd_addr is not sampled.
- The write port is unaffected by rd_clk_en.

Reset
- rst_n low forces rd_data and rd_q to 0 immediately, regardless of clk.
- Release is synchronous to the next rising edge; the first read after release completes normally.
- Reset asserted mid-sequence discards in-flight read data but leaves memory intact.

Read-during-write
- When wr_addr == rd_addr with wr_en=1 and rd_clk_en=1 on the same edge, the read returns the OLD contents (read-first). The new value is visible to a read issued on the following cycle.

Addressing
- Addresses are unsigned and wrap naturally at ADDR_WIDTH bits.
- No out-of-range condition exists.

Widths
- wr_data and rd_data are the same width; no width conversion.

Test Plan:
- Reset: rst_n=0 for 200 ns with rd_clk_en=1 -> rd_data=0x000 throughout. Release, then read any address -> value from the array after 1 cycle.
- Full sweep: write mem[a]=0x1FF-(a mod 512) for a=0..2047 with wr_en=1 every cycle, then read a=0..2047 back-to-back with rd_clk_en=1 -> rd_data at cycle a+1 equals 0x1FF-(a mod 512), zero mismatches.
- Latency: OUTPUT_REG=1, write mem[5]=0x0AB, present rd_addr=5 -> rd_data=0x0AB exactly 2 cycles later; OUTPUT_REG=0 -> 1 cycle later.
- Clock enable: read mem[3]=0x155 so rd_data=0x155, then rd_clk_en=0 and rd_addr=4 (mem[4]=0x0AA) for 5 cycles -> rd_data stays 0x155. Re-enable -> 0x0AA next cycle.
- Read-during-write: mem[7]=0x011, then same edge wr_en=1, wr_addr=7, wr_data=0x1EE, rd_addr=7 -> rd_data=0x011. Next-cycle read of 7 -> 0x1EE.
- Mid-operation reset: fill mem[0..15], pulse rst_n low for 1 cycle during a read sweep -> rd_data=0 while low. After release, re-read mem[0..15] -> original values, memory preserved.
